// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM encoding and default widths for the multiply-accumulate path
package mul_pkg;
  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W = 24;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sat_adder.sv
// sat_adder: unsigned a+b clamped to all-ones, flagging when the clamp applies
module sat_adder #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  logic [W:0] raw;
  assign raw = {1'b0, a} + {1'b0, b};
  assign ovf = raw[W];
  assign sum = raw[W] ? '1 : raw[W-1:0];
endmodule

// File: rtl/mul_accumulator.sv
// mul_accumulator: sums a programmed batch of multiplier products with saturation
module mul_accumulator
  import mul_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              start,
  input  logic [CNT_W-1:0]  batch_len,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              sat,
  output logic              busy
);
  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] len;
  logic [ACC_W-1:0] sum;
  logic             ovf;
  sat_adder #(.W(ACC_W)) u_add (
    .a  (acc_out),
    .b  (ACC_W'(prod_in)),
    .sum(sum),
    .ovf(ovf)
  );
  // Handshake outputs decode from state alone so no input reaches an output combinationally.
  assign prod_ready = state == ST_ACC;
  assign acc_valid = state == ST_DONE;
  assign busy = state != ST_IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      acc_out <= '0;
      count <= '0;
      len <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      state <= ST_IDLE;
      acc_out <= '0;
      count <= '0;
      sat <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          len <= batch_len;
          acc_out <= '0;
          count <= '0;
          sat <= 1'b0;
          state <= batch_len == '0 ? ST_DONE : ST_ACC;
        end
        ST_ACC: if (prod_valid) begin
          acc_out <= sum;
          sat <= sat | ovf;
          count <= count + CNT_W'(1);
          if (count == len - CNT_W'(1)) state <= ST_DONE;
        end
        ST_DONE: if (acc_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_accumulator.sv
// tb_mul_accumulator: directed and random batches on 24-bit and 20-bit accumulators
module tb_mul_accumulator;
  logic clk = 1'b0, reset = 1'b1, clr = 1'b0, start = 1'b0;
  logic prod_valid = 1'b0, acc_ready = 1'b0;
  logic [7:0] batch_len = '0;
  logic [15:0] prod_in = '0;
  logic prod_ready_a, acc_valid_a, sat_a, busy_a;
  logic prod_ready_b, acc_valid_b, sat_b, busy_b;
  logic [23:0] acc_out_a;
  logic [19:0] acc_out_b;
  int checks = 0, failures = 0;
  longint unsigned total;
  logic [63:0] held_a, held_b;
  always #5 clk = ~clk;
  mul_accumulator #(.ACC_W(24)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .start(start), .batch_len(batch_len),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready_a),
    .acc_out(acc_out_a), .acc_valid(acc_valid_a), .acc_ready(acc_ready),
    .sat(sat_a), .busy(busy_a)
  );
  mul_accumulator #(.ACC_W(20)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .start(start), .batch_len(batch_len),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready_b),
    .acc_out(acc_out_b), .acc_valid(acc_valid_b), .acc_ready(acc_ready),
    .sat(sat_b), .busy(busy_b)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] lim(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
  function automatic logic [63:0] clip(input longint unsigned t, input int w);
    return t > lim(w) ? lim(w) : t;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic all_zero(input string tag);
    chk({tag, ".acc_a"}, acc_out_a, 0);
    chk({tag, ".acc_b"}, acc_out_b, 0);
    chk({tag, ".flags_a"}, {prod_ready_a, acc_valid_a, sat_a, busy_a}, 0);
    chk({tag, ".flags_b"}, {prod_ready_b, acc_valid_b, sat_b, busy_b}, 0);
  endtask
  task automatic begin_batch(input logic [7:0] l);
    total = 0;
    start = 1'b1;
    batch_len = l;
    step();
    start = 1'b0;
    batch_len = 8'($urandom);
  endtask
  task automatic feed(input logic [15:0] p, input int gap);
    repeat (gap) begin
      prod_valid = 1'b0;
      prod_in = 16'($urandom);
      step();
      chk("gap.ready", {prod_ready_a, prod_ready_b}, 2'b11);
    end
    chk("feed.not_done", {acc_valid_a, acc_valid_b}, 0);
    prod_valid = 1'b1;
    prod_in = p;
    step();
    prod_valid = 1'b0;
    total += p;
  endtask
  task automatic chk_done(input string tag);
    chk({tag, ".valid"}, {acc_valid_a, acc_valid_b, busy_a, busy_b}, 4'hf);
    chk({tag, ".ready"}, {prod_ready_a, prod_ready_b}, 0);
    chk({tag, ".acc_a"}, acc_out_a, clip(total, 24));
    chk({tag, ".acc_b"}, acc_out_b, clip(total, 20));
    chk({tag, ".sat_a"}, sat_a, total > lim(24));
    chk({tag, ".sat_b"}, sat_b, total > lim(20));
  endtask
  task automatic take(input string tag);
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    chk({tag, ".idle"}, {busy_a, busy_b, acc_valid_a, acc_valid_b}, 0);
  endtask
  initial begin
    #12;
    all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    step();
    all_zero("post_reset");
    begin_batch(3);
    feed(16'h0010, 0);
    feed(16'h0020, 0);
    feed(16'h0030, 0);
    chk_done("t1");
    chk("t1.exact", acc_out_a, 64'h60);
    take("t1");
    begin_batch(20);
    repeat (20) feed(16'hffff, 0);
    chk_done("t2");
    chk("t2.sat_const", {acc_out_b, sat_b}, {20'hfffff, 1'b1});
    take("t2");
    begin_batch(1);
    feed(16'h0001, 0);
    chk_done("t2b");
    chk("t2b.cleared", {acc_out_b, sat_b}, {20'h00001, 1'b0});
    take("t2b");
    begin_batch(2);
    feed(16'h1111, 3);
    feed(16'h2222, 3);
    chk_done("t3");
    held_a = 64'(acc_out_a);
    held_b = 64'(acc_out_b);
    for (int i = 0; i < 5; i++) begin
      prod_valid = 1'($urandom);
      prod_in = 16'($urandom);
      start = i == 2;
      batch_len = 8'd5;
      step();
      chk("t3.hold_acc", {acc_out_a, acc_out_b}, {held_a[23:0], held_b[19:0]});
      chk("t3.hold_flags", {acc_valid_a, prod_ready_a, acc_valid_b, prod_ready_b}, 4'b1010);
    end
    prod_valid = 1'b0;
    start = 1'b0;
    take("t3");
    chk("t3.idle_keeps", acc_out_a, held_a);
    begin_batch(0);
    chk_done("t4");
    take("t4");
    begin_batch(4);
    feed(16'h0100, 0);
    feed(16'h0200, 0);
    prod_valid = 1'b1;
    prod_in = 16'h0300;
    clr = 1'b1;
    step();
    clr = 1'b0;
    prod_valid = 1'b0;
    all_zero("t5.clr");
    repeat (3) step();
    all_zero("t5.after");
    begin_batch(3);
    feed(16'h0055, 0);
    #3 reset = 1'b1;
    #1 all_zero("t6.async");
    #2 reset = 1'b0;
    step();
    all_zero("t6.release");
    begin_batch(1);
    feed(16'h1234, 0);
    chk_done("t6");
    chk("t6.exact", acc_out_a, 64'h1234);
    take("t6");
    for (int n = 0; n < 10; n++) begin
      int l;
      l = $urandom_range(1, 24);
      begin_batch(8'(l));
      for (int k = 0; k < l; k++) feed(16'($urandom), $urandom_range(0, 2));
      chk_done("rand");
      take("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
